// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared encodings for the ID/EX hazard controller: operand-select codes
// and the multiplier scoreboard state machine.
package hazard_scoreboard_unit_pkg;

    // ALU operand mux select codes
    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Multiplier occupancy states
    typedef enum logic [1:0] {
        HZ_IDLE = 2'd0,
        HZ_BUSY = 2'd1,
        HZ_WB   = 2'd2
    } hz_state_e;

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one EX-stage source operand. EX/MEM results are
// newer than MEM/WB results, so they take priority; register 0 never forwards.
module fwd_select
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_regwrite,
    output logic [1:0]        sel
);

    // Pick the youngest in-flight producer of this source register
    always_comb begin
        sel = FWD_NONE;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src)) begin
            sel = FWD_EXMEM;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID/EX hazard controller: EX operand forwarding, load-use stall, branch
// flush and a pending-register scoreboard for one non-pipelined multiplier.
// A taken branch overrides every stall reason: the ID instruction is squashed
// anyway, so holding the PC would only lose the branch target.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int MUL_LAT = 4,
    parameter int PCNT_W  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dst,
    input  logic                      id_regwrite,
    input  logic                      id_is_mul,
    input  logic [NUM_SRC*REG_AW-1:0] idex_src,
    input  logic [REG_AW-1:0]         idex_rd,
    input  logic                      idex_memread,
    input  logic [REG_AW-1:0]         exmem_rd,
    input  logic                      exmem_regwrite,
    input  logic [REG_AW-1:0]         memwb_rd,
    input  logic                      memwb_regwrite,
    input  logic                      branch_taken,
    output logic [2*NUM_SRC-1:0]      forward,
    output logic                      stall,
    output logic                      bubble,
    output logic                      flush_ifid,
    output logic                      mul_busy,
    output logic                      mul_wb,
    output logic [REG_AW-1:0]         mul_wb_rd,
    output logic [PCNT_W-1:0]         stall_cycles
);

    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int CNT_W    = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    hz_state_e           state;
    logic [CNT_W-1:0]    count;
    logic [REG_AW-1:0]   mul_dst;
    logic [NUM_REGS-1:0] pending;

    logic hz_ld;
    logic hz_raw;
    logic hz_waw;
    logic hz_struct;
    logic issue;

    // One forwarding selector per EX-stage source operand
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        fwd_select #(.REG_AW(REG_AW)) u_fwd (
            .src            (idex_src[i*REG_AW +: REG_AW]),
            .exmem_rd       (exmem_rd),
            .exmem_regwrite (exmem_regwrite),
            .memwb_rd       (memwb_rd),
            .memwb_regwrite (memwb_regwrite),
            .sel            (forward[2*i +: 2])
        );
    end

    // Hazard detection over every used ID source operand
    always_comb begin
        hz_ld  = 1'b0;
        hz_raw = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i]) begin
                if (idex_memread && (idex_rd != '0) &&
                    (id_src[i*REG_AW +: REG_AW] == idex_rd)) begin
                    hz_ld = 1'b1;
                end
                if (pending[id_src[i*REG_AW +: REG_AW]]) begin
                    hz_raw = 1'b1;
                end
            end
        end
        hz_waw    = id_regwrite && pending[id_dst];
        hz_struct = id_is_mul && (state == HZ_BUSY);
    end

    // Pipeline control; the branch squash dominates all stall reasons
    always_comb begin
        stall      = id_valid && !branch_taken && (hz_ld | hz_raw | hz_waw | hz_struct);
        bubble     = stall | branch_taken;
        flush_ifid = branch_taken;
        issue      = id_valid && id_is_mul && !stall && !branch_taken;
        mul_busy   = (state == HZ_BUSY);
    end

    // Multiplier occupancy FSM with registered writeback strobe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= HZ_IDLE;
            count     <= '0;
            mul_dst   <= '0;
            mul_wb    <= 1'b0;
            mul_wb_rd <= '0;
        end else begin
            case (state)
                HZ_IDLE: begin
                    mul_wb <= 1'b0;
                    if (issue) begin
                        state   <= HZ_BUSY;
                        count   <= CNT_W'(MUL_LAT - 1);
                        mul_dst <= id_dst;
                    end
                end
                HZ_BUSY: begin
                    if (count == '0) begin
                        state     <= HZ_WB;
                        mul_wb    <= 1'b1;
                        mul_wb_rd <= mul_dst;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                HZ_WB: begin
                    mul_wb <= 1'b0;
                    if (issue) begin
                        state   <= HZ_BUSY;
                        count   <= CNT_W'(MUL_LAT - 1);
                        mul_dst <= id_dst;
                    end else begin
                        state <= HZ_IDLE;
                    end
                end
                default: begin
                    state  <= HZ_IDLE;
                    mul_wb <= 1'b0;
                end
            endcase
        end
    end

    // Pending-register scoreboard; a same-cycle set overrides the WB clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            if (state == HZ_WB) begin
                pending[mul_dst] <= 1'b0;
            end
            if (issue && (id_dst != '0)) begin
                pending[id_dst] <= 1'b1;
            end
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit (MUL_LAT = 4, PCNT_W = 4).
module tb_hazard_scoreboard_unit;

    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int MUL_LAT = 4;
    localparam int PCNT_W  = 4;

    logic                      clock;
    logic                      reset;
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [REG_AW-1:0]         id_dst;
    logic                      id_regwrite;
    logic                      id_is_mul;
    logic [NUM_SRC*REG_AW-1:0] idex_src;
    logic [REG_AW-1:0]         idex_rd;
    logic                      idex_memread;
    logic [REG_AW-1:0]         exmem_rd;
    logic                      exmem_regwrite;
    logic [REG_AW-1:0]         memwb_rd;
    logic                      memwb_regwrite;
    logic                      branch_taken;
    logic [2*NUM_SRC-1:0]      forward;
    logic                      stall;
    logic                      bubble;
    logic                      flush_ifid;
    logic                      mul_busy;
    logic                      mul_wb;
    logic [REG_AW-1:0]         mul_wb_rd;
    logic [PCNT_W-1:0]         stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard_unit #(
        .REG_AW (REG_AW),
        .NUM_SRC(NUM_SRC),
        .MUL_LAT(MUL_LAT),
        .PCNT_W (PCNT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_src         (id_src),
        .id_src_used    (id_src_used),
        .id_dst         (id_dst),
        .id_regwrite    (id_regwrite),
        .id_is_mul      (id_is_mul),
        .idex_src       (idex_src),
        .idex_rd        (idex_rd),
        .idex_memread   (idex_memread),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .branch_taken   (branch_taken),
        .forward        (forward),
        .stall          (stall),
        .bubble         (bubble),
        .flush_ifid     (flush_ifid),
        .mul_busy       (mul_busy),
        .mul_wb         (mul_wb),
        .mul_wb_rd      (mul_wb_rd),
        .stall_cycles   (stall_cycles)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid       = 1'b0;
        id_src         = '0;
        id_src_used    = '0;
        id_dst         = '0;
        id_regwrite    = 1'b0;
        id_is_mul      = 1'b0;
        idex_src       = '0;
        idex_rd        = '0;
        idex_memread   = 1'b0;
        exmem_rd       = '0;
        exmem_regwrite = 1'b0;
        memwb_rd       = '0;
        memwb_regwrite = 1'b0;
        branch_taken   = 1'b0;
    endtask

    task automatic drive_mul(input logic [REG_AW-1:0] dst);
        clear_inputs();
        id_valid    = 1'b1;
        id_is_mul   = 1'b1;
        id_regwrite = 1'b1;
        id_dst      = dst;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #3;
        n_checks++;
        if (mul_busy !== 1'b0 || mul_wb !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fsm: busy=%b wb=%b want 0 0", mul_busy, mul_wb);
        end
        n_checks++;
        if (mul_wb_rd !== 5'd0 || stall_cycles !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_regs: wb_rd=%0d cnt=%0d want 0 0", mul_wb_rd, stall_cycles);
        end
        n_checks++;
        if (stall !== 1'b0 || bubble !== 1'b0 || flush_ifid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: stall=%b bubble=%b flush=%b want 000", stall, bubble, flush_ifid);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        exmem_rd       = 5'd3;
        exmem_regwrite = 1'b1;
        memwb_rd       = 5'd3;
        memwb_regwrite = 1'b1;
        idex_src[4:0]  = 5'd3;
        idex_src[9:5]  = 5'd4;
        #1;
        n_checks++;
        if (forward !== 4'b0010) begin
            n_fail++;
            $display("FAIL fwd_exmem_prio: got %b want 0010", forward);
        end
        exmem_regwrite = 1'b0;
        #1;
        n_checks++;
        if (forward !== 4'b0001) begin
            n_fail++;
            $display("FAIL fwd_memwb: got %b want 0001", forward);
        end
        exmem_rd       = 5'd0;
        exmem_regwrite = 1'b1;
        memwb_rd       = 5'd0;
        idex_src[4:0]  = 5'd0;
        #1;
        n_checks++;
        if (forward !== 4'b0000) begin
            n_fail++;
            $display("FAIL fwd_r0: got %b want 0000", forward);
        end
        // Second source: EXMEM on src1, MEMWB on src0
        exmem_rd      = 5'd4;
        memwb_rd      = 5'd6;
        idex_src[4:0] = 5'd6;
        #1;
        n_checks++;
        if (forward !== 4'b1001) begin
            n_fail++;
            $display("FAIL fwd_two_src: got %b want 1001", forward);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        id_valid      = 1'b1;
        idex_memread  = 1'b1;
        idex_rd       = 5'd8;
        id_src[9:5]   = 5'd8;
        id_src_used   = 2'b10;
        #1;
        n_checks++;
        if (stall !== 1'b1 || bubble !== 1'b1 || flush_ifid !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_use: stall=%b bubble=%b flush=%b want 110", stall, bubble, flush_ifid);
        end
        tick();
        // Bubble moved into EX: the load has advanced
        idex_memread = 1'b0;
        idex_rd      = 5'd0;
        #1;
        n_checks++;
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_use_release: stall=%b bubble=%b want 00", stall, bubble);
        end
        n_checks++;
        if (stall_cycles !== 4'd1) begin
            n_fail++;
            $display("FAIL ld_use_count: got %0d want 1", stall_cycles);
        end
        idex_memread = 1'b1;
        idex_rd      = 5'd8;
        id_src_used  = 2'b01;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_use_unused: stall=%b want 0", stall);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_mul_raw();
        drive_mul(5'd5);
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_issue: stall=%b want 0", stall);
        end
        tick();
        clear_inputs();
        id_valid    = 1'b1;
        id_src[4:0] = 5'd5;
        id_src_used = 2'b01;
        id_regwrite = 1'b1;
        id_dst      = 5'd6;
        for (int k = 1; k <= 5; k++) begin
            #1;
            n_checks++;
            if (stall !== 1'b1 || mul_wb !== (k == 5) || mul_busy !== (k != 5)) begin
                n_fail++;
                $display("FAIL raw_cycle%0d: stall=%b wb=%b busy=%b want 1 %b %b",
                         k, stall, mul_wb, mul_busy, (k == 5), (k != 5));
            end
            if (k == 5) begin
                n_checks++;
                if (mul_wb_rd !== 5'd5) begin
                    n_fail++;
                    $display("FAIL raw_wb_rd: got %0d want 5", mul_wb_rd);
                end
            end
            tick();
        end
        #1;
        n_checks++;
        if (stall !== 1'b0 || mul_wb !== 1'b0 || mul_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_release: stall=%b wb=%b busy=%b want 000", stall, mul_wb, mul_busy);
        end
        n_checks++;
        if (stall_cycles !== 4'd6) begin
            n_fail++;
            $display("FAIL raw_count: got %0d want 6", stall_cycles);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_struct_waw();
        drive_mul(5'd5);
        tick();
        clear_inputs();
        tick();
        drive_mul(5'd7);
        for (int k = 2; k <= 4; k++) begin
            #1;
            n_checks++;
            if (stall !== 1'b1) begin
                n_fail++;
                $display("FAIL struct_cycle%0d: stall=%b want 1", k, stall);
            end
            tick();
        end
        #1;
        n_checks++;
        if (stall !== 1'b0 || mul_wb !== 1'b1 || mul_wb_rd !== 5'd5) begin
            n_fail++;
            $display("FAIL struct_wb_issue: stall=%b wb=%b rd=%0d want 0 1 5", stall, mul_wb, mul_wb_rd);
        end
        tick();
        clear_inputs();
        id_valid    = 1'b1;
        id_regwrite = 1'b1;
        id_dst      = 5'd7;
        #1;
        n_checks++;
        if (mul_busy !== 1'b1 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_stall: busy=%b stall=%b want 1 1", mul_busy, stall);
        end
        // Old destination r5 must be free again
        id_dst = 5'd5;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_cleared: stall=%b want 0", stall);
        end
        id_dst = 5'd7;
        for (int k = 0; k < 4; k++) tick();
        #1;
        n_checks++;
        if (mul_wb !== 1'b1 || mul_wb_rd !== 5'd7 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_wb: wb=%b rd=%0d stall=%b want 1 7 1", mul_wb, mul_wb_rd, stall);
        end
        tick();
        #1;
        n_checks++;
        if (stall !== 1'b0 || mul_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_release: stall=%b busy=%b want 0 0", stall, mul_busy);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_flush();
        drive_mul(5'd10);
        branch_taken = 1'b1;
        idex_memread = 1'b1;
        idex_rd      = 5'd8;
        id_src[9:5]  = 5'd8;
        id_src_used  = 2'b10;
        #1;
        n_checks++;
        if (flush_ifid !== 1'b1 || bubble !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ctrl: flush=%b bubble=%b stall=%b want 1 1 0", flush_ifid, bubble, stall);
        end
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if (mul_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_issue: busy=%b want 0", mul_busy);
        end
        drive_mul(5'd9);
        tick();
        clear_inputs();
        branch_taken = 1'b1;
        idex_memread = 1'b1;
        idex_rd      = 5'd8;
        id_valid     = 1'b1;
        id_src[9:5]  = 5'd8;
        id_src_used  = 2'b10;
        #1;
        n_checks++;
        if (flush_ifid !== 1'b1 || stall !== 1'b0 || mul_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_inflight: flush=%b stall=%b busy=%b want 1 0 1", flush_ifid, stall, mul_busy);
        end
        tick();
        clear_inputs();
        for (int k = 0; k < 3; k++) tick();
        #1;
        n_checks++;
        if (mul_wb !== 1'b1 || mul_wb_rd !== 5'd9) begin
            n_fail++;
            $display("FAIL flush_wb: wb=%b rd=%0d want 1 9", mul_wb, mul_wb_rd);
        end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        drive_mul(5'd5);
        tick();
        clear_inputs();
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (mul_busy !== 1'b0 || stall_cycles !== 4'd0 || mul_wb !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy: busy=%b cnt=%0d wb=%b want 0 0 0", mul_busy, stall_cycles, mul_wb);
        end
        id_valid    = 1'b1;
        id_src[4:0] = 5'd5;
        id_src_used = 2'b01;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pending: stall=%b want 0", stall);
        end
        clear_inputs();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (mul_wb !== 1'b0 || mul_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_wb%0d: wb=%b busy=%b want 0 0", k, mul_wb, mul_busy);
            end
        end
    endtask

    task automatic test_saturation();
        clear_inputs();
        id_valid     = 1'b1;
        idex_memread = 1'b1;
        idex_rd      = 5'd12;
        id_src[4:0]  = 5'd12;
        id_src_used  = 2'b01;
        for (int k = 0; k < 14; k++) tick();
        n_checks++;
        if (stall_cycles !== 4'd14) begin
            n_fail++;
            $display("FAIL sat_14: got %0d want 14", stall_cycles);
        end
        tick();
        n_checks++;
        if (stall_cycles !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_15: got %0d want 15", stall_cycles);
        end
        for (int k = 0; k < 3; k++) tick();
        n_checks++;
        if (stall_cycles !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d want 15", stall_cycles);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mul_raw();
        test_struct_waw();
        test_flush();
        test_reset_mid_busy();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
